// File: rtl/select_ready_rr.sv
// select_ready_rr: registered N-way selector with urgent/normal classes and
// round-robin fairness inside each class. The grant is held until accepted or
// withdrawn by its requester.
// Optional build macro: SELECT_READY_AGING_EN (age-based promotion of normal
// requests into the urgent class).
module select_ready_rr #(
    parameter int unsigned N         = 4,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned AGE_W     = 4,
    parameter int unsigned AGE_LIMIT = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    ready,
    input  logic [N-1:0]    ready_urgent,
    input  logic            accept,
    output logic [N-1:0]    sel,
    output logic [ID_W-1:0] sel_id,
    output logic            sel_valid,
    output logic            sel_valid_urgent
);

    // Reject configurations the arbitration logic cannot represent.
    if (N < 2 || ID_W != $clog2(N) || AGE_LIMIT >= (2 ** AGE_W)) begin : g_bad_cfg
        $error("select_ready_rr: illegal parameter combination");
    end

    logic [N-1:0]    req;
    logic [N-1:0]    urg;
    logic [N-1:0]    promoted;
    logic            do_accept;
    logic            withdrawn;
    logic            load;
    logic [ID_W-1:0] next_id;
    logic [ID_W-1:0] ptr_u, ptr_u_d;
    logic [ID_W-1:0] ptr_n, ptr_n_d;
    logic            found_u, found_n;
    logic [ID_W-1:0] win_u, win_n;
    logic [ID_W-1:0] cand_u, cand_n;
    logic [N-1:0]    sel_d;
    logic [ID_W-1:0] sel_id_d;
    logic            sel_valid_d;
    logic            sel_valid_urgent_d;

`ifdef SELECT_READY_AGING_EN
    logic [AGE_W-1:0] age_q [N];

    // Per-requester wait counters: count while waiting in the normal class,
    // clear when the request goes away or is served.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!ready[i] || (do_accept && sel_id == ID_W'(i))) begin
                    age_q[i] <= '0;
                end else if (!ready_urgent[i] && !(sel_valid && sel_id == ID_W'(i)) &&
                             age_q[i] != AGE_W'(AGE_LIMIT)) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    // A requester that has waited AGE_LIMIT cycles contends as urgent.
    always_comb begin
        promoted = '0;
        for (int unsigned i = 0; i < N; i++) begin
            promoted[i] = (age_q[i] == AGE_W'(AGE_LIMIT));
        end
    end
`else
    // No aging: the urgent class is driven by ready_urgent alone.
    always_comb begin
        promoted = '0;
    end
`endif

    // Load decision, pointer advance and two-class rotating search.
    always_comb begin
        req       = ready | ready_urgent;
        urg       = ready_urgent | promoted;
        do_accept = sel_valid & accept;
        withdrawn = sel_valid & !accept & !req[sel_id];
        load      = !sel_valid | accept | withdrawn;

        next_id = (sel_id == ID_W'(N - 1)) ? '0 : sel_id + 1'b1;
        ptr_u_d = ptr_u;
        ptr_n_d = ptr_n;
        if (do_accept) begin
            if (sel_valid_urgent) begin
                ptr_u_d = next_id;
            end else begin
                ptr_n_d = next_id;
            end
        end

        // Search from the already-advanced pointers so the accepted
        // requester goes to the back of its class on back-to-back grants.
        found_u = 1'b0;
        found_n = 1'b0;
        win_u   = '0;
        win_n   = '0;
        cand_u  = '0;
        cand_n  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand_u = ID_W'((32'(ptr_u_d) + k) % N);
            cand_n = ID_W'((32'(ptr_n_d) + k) % N);
            if (!found_u && urg[cand_u]) begin
                found_u = 1'b1;
                win_u   = cand_u;
            end
            if (!found_n && req[cand_n]) begin
                found_n = 1'b1;
                win_n   = cand_n;
            end
        end

        sel_d              = sel;
        sel_id_d           = sel_id;
        sel_valid_d        = sel_valid;
        sel_valid_urgent_d = sel_valid_urgent;
        if (load) begin
            if (found_u) begin
                sel_d              = N'(1) << win_u;
                sel_id_d           = win_u;
                sel_valid_d        = 1'b1;
                sel_valid_urgent_d = 1'b1;
            end else if (found_n) begin
                sel_d              = N'(1) << win_n;
                sel_id_d           = win_n;
                sel_valid_d        = 1'b1;
                sel_valid_urgent_d = 1'b0;
            end else begin
                sel_d              = '0;
                sel_id_d           = '0;
                sel_valid_d        = 1'b0;
                sel_valid_urgent_d = 1'b0;
            end
        end
    end

    // Grant outputs and round-robin pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel              <= '0;
            sel_id           <= '0;
            sel_valid        <= 1'b0;
            sel_valid_urgent <= 1'b0;
            ptr_u            <= '0;
            ptr_n            <= '0;
        end else begin
            sel              <= sel_d;
            sel_id           <= sel_id_d;
            sel_valid        <= sel_valid_d;
            sel_valid_urgent <= sel_valid_urgent_d;
            ptr_u            <= ptr_u_d;
            ptr_n            <= ptr_n_d;
        end
    end

endmodule

// File: tb/tb_select_ready_rr.sv
// Directed bench for select_ready_rr (default build, N=4).
module tb_select_ready_rr;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] ready;
    logic [3:0] ready_urgent;
    logic       accept;
    logic [3:0] sel;
    logic [1:0] sel_id;
    logic       sel_valid;
    logic       sel_valid_urgent;

    select_ready_rr #(.N(4), .ID_W(2), .AGE_W(4), .AGE_LIMIT(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .ready            (ready),
        .ready_urgent     (ready_urgent),
        .accept           (accept),
        .sel              (sel),
        .sel_id           (sel_id),
        .sel_valid        (sel_valid),
        .sel_valid_urgent (sel_valid_urgent)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       rst;
        logic [3:0] rdy;
        logic [3:0] urg;
        logic       acc;
        logic [3:0] e_sel;
        logic [1:0] e_id;
        logic       e_v;
        logic       e_u;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] rd, input logic [3:0] ur,
                                input logic ac, input logic [3:0] es, input logic [1:0] ei,
                                input logic ev, input logic eu);
        vec_t v;
        v.rst = r; v.rdy = rd; v.urg = ur; v.acc = ac;
        v.e_sel = es; v.e_id = ei; v.e_v = ev; v.e_u = eu;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] es, input logic [1:0] ei,
                         input logic ev, input logic eu);
        n_vec++;
        if (sel !== es || sel_id !== ei || sel_valid !== ev || sel_valid_urgent !== eu) begin
            n_bad++;
            $display("FAIL %s: got sel=%b id=%0d v=%b u=%b, want sel=%b id=%0d v=%b u=%b",
                     name, sel, sel_id, sel_valid, sel_valid_urgent, es, ei, ev, eu);
        end
    endtask

    initial begin
        int waited;
        // reset held with all ready, then first grant
        for (int i = 0; i < 3; i++) vecs[i] = mk(1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0);
        vecs[3]  = mk(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, 1, 0);
        // round robin with accept every cycle
        vecs[4]  = mk(0, 4'b1111, 4'b0000, 1, 4'b0010, 1, 1, 0);
        vecs[5]  = mk(0, 4'b1111, 4'b0000, 1, 4'b0100, 2, 1, 0);
        vecs[6]  = mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, 1, 0);
        vecs[7]  = mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 1, 0);
        // hold without pre-emption, then urgent wins after accept
        vecs[8]  = mk(0, 4'b0011, 4'b0000, 0, 4'b0001, 0, 1, 0);
        for (int i = 9; i < 14; i++) vecs[i] = mk(0, 4'b0011, 4'b1000, 0, 4'b0001, 0, 1, 0);
        vecs[14] = mk(0, 4'b0011, 4'b1000, 1, 4'b1000, 3, 1, 1);
        vecs[15] = mk(0, 4'b0011, 4'b0000, 1, 4'b0010, 1, 1, 0);
        vecs[16] = mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
        // accept while idle is ignored: ptr_n stays 2
        vecs[17] = mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);
        vecs[18] = mk(0, 4'b1111, 4'b0000, 0, 4'b0100, 2, 1, 0);
        // reset mid-grant with accept pending
        vecs[19] = mk(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0);
        // withdrawal re-arbitrates without moving ptr_n
        vecs[20] = mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 2, 1, 0);
        vecs[21] = mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 2, 1, 0);
        vecs[22] = mk(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 0);
        vecs[23] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);
        vecs[24] = mk(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, 1, 0);
        // permanent urgent requester starves normal requester 3 (no aging)
        for (int i = 25; i < 30; i++) vecs[i] = mk(0, 4'b1000, 4'b0001, 1, 4'b0001, 0, 1, 1);
        // urgent round robin, then fall back to normal class
        vecs[30] = mk(0, 4'b0000, 4'b1111, 1, 4'b0010, 1, 1, 1);
        vecs[31] = mk(0, 4'b0000, 4'b1111, 1, 4'b0100, 2, 1, 1);
        vecs[32] = mk(0, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0);
        vecs[33] = mk(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            reset        = vecs[i].rst;
            ready        = vecs[i].rdy;
            ready_urgent = vecs[i].urg;
            accept       = vecs[i].acc;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_id, vecs[i].e_v, vecs[i].e_u);
        end

        // latency from idle, bounded wait for the first grant
        reset = 1'b1; ready = 4'b0000; ready_urgent = 4'b0000; accept = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        ready = 4'b0110;
        waited = 0;
        while (waited < 4) begin
            @(posedge clock);
            #1;
            waited++;
            if (sel_valid) break;
        end
        n_vec++;
        if (waited != 1) begin
            n_bad++;
            $display("FAIL seq_latency: got %0d cycles, want 1", waited);
        end
        check("seq_first", 4'b0010, 2'd1, 1'b1, 1'b0);

        // back-to-back accepts alternate between the two requesters
        accept = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (i % 2 == 0) check($sformatf("seq_alt%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
            else            check($sformatf("seq_alt%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
